// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-SRAM port arbiter: FSM states and access owner IDs.
package dmem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_RDW  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive arbitration losses by the loader port.
module arb_wait_counter #(
  parameter int MAX_WAIT = 8,
  localparam int CW = $clog2(MAX_WAIT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          at_max
);

  assign at_max = (cnt == CW'(MAX_WAIT));

  // Clear dominates increment so a grant in the same cycle always restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data SRAM between the core data port (C, priority) and the
// loader port (L), with a starvation guard that forces an L grant after MAX_WAIT losses.
module dmem_port_arbiter #(
  parameter int AW       = 7,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cpu_req,
  input  logic                           cpu_we,
  input  logic [AW-1:0]                  cpu_addr,
  input  logic [DW-1:0]                  cpu_wdata,
  output logic                           cpu_ack,
  output logic [DW-1:0]                  cpu_rdata,
  output logic                           cpu_stall,
  input  logic                           ldr_req,
  input  logic                           ldr_we,
  input  logic [AW-1:0]                  ldr_addr,
  input  logic [DW-1:0]                  ldr_wdata,
  output logic                           ldr_ack,
  output logic [DW-1:0]                  ldr_rdata,
  output logic                           CEN,
  output logic                           WEN,
  output logic                           OEN,
  output logic [AW-1:0]                  A,
  output logic [DW-1:0]                  Data2Mem,
  input  logic [DW-1:0]                  ReadDataMem,
  output logic [1:0]                     state_dbg,
  output logic [$clog2(MAX_WAIT+1)-1:0]  wait_cnt_dbg
);
  import dmem_arb_pkg::*;

  // Handshake: a requester raises req with we/addr/wdata and holds all of them stable
  // until its one-cycle ack; req still high in the following IDLE is a new request.

  logic [1:0]    state;
  logic          owner;
  logic          is_wr;
  logic [2:0]    lat_cnt;
  logic          l_win;
  logic          any_req;
  logic          wait_max;
  logic          wait_inc;
  logic          wait_clr;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign state_dbg = state;
  assign cpu_stall = cpu_req & ~cpu_ack;

  always_comb begin
    any_req   = cpu_req | ldr_req;
    l_win     = ldr_req & (~cpu_req | wait_max);
    sel_we    = l_win ? ldr_we    : cpu_we;
    sel_addr  = l_win ? ldr_addr  : cpu_addr;
    sel_wdata = l_win ? ldr_wdata : cpu_wdata;
    wait_inc  = (state == ST_IDLE) & ldr_req & ~l_win;
    wait_clr  = ~ldr_req | ((state == ST_IDLE) & l_win);
  end

  arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait_counter (
    .clk    (clk),
    .rst    (rst),
    .inc    (wait_inc),
    .clr    (wait_clr),
    .cnt    (wait_cnt_dbg),
    .at_max (wait_max)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_CPU;
      is_wr     <= 1'b0;
      lat_cnt   <= 3'd0;
      CEN       <= 1'b1;
      WEN       <= 1'b1;
      OEN       <= 1'b1;
      A         <= '0;
      Data2Mem  <= '0;
      cpu_ack   <= 1'b0;
      ldr_ack   <= 1'b0;
      cpu_rdata <= '0;
      ldr_rdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      ldr_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner    <= l_win ? OWN_LDR : OWN_CPU;
            is_wr    <= sel_we;
            A        <= sel_addr;
            Data2Mem <= sel_wdata;
            CEN      <= 1'b0;
            WEN      <= ~sel_we;
            OEN      <= sel_we;
            state    <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (is_wr) begin
            CEN     <= 1'b1;
            WEN     <= 1'b1;
            OEN     <= 1'b1;
            cpu_ack <= (owner == OWN_CPU);
            ldr_ack <= (owner == OWN_LDR);
            state   <= ST_DONE;
          end else begin
            lat_cnt <= 3'(RD_LAT - 1);
            state   <= ST_RDW;
          end
        end
        ST_RDW: begin
          // Strobes and address stay put until the last wait cycle delivers the word.
          if (lat_cnt == 3'd0) begin
            if (owner == OWN_CPU) cpu_rdata <= ReadDataMem;
            else                  ldr_rdata <= ReadDataMem;
            CEN     <= 1'b1;
            WEN     <= 1'b1;
            OEN     <= 1'b1;
            cpu_ack <= (owner == OWN_CPU);
            ldr_ack <= (owner == OWN_LDR);
            state   <= ST_DONE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of arbitration, access lengths and memory contents.
module tb_dmem_port_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int RD_LAT = 1;
  localparam int MAX_WAIT = 8;
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic clk = 1'b0;
  logic rst;
  logic cpu_req, cpu_we, ldr_req, ldr_we;
  logic [AW-1:0] cpu_addr, ldr_addr, A;
  logic [DW-1:0] cpu_wdata, ldr_wdata, cpu_rdata, ldr_rdata, Data2Mem, ReadDataMem;
  logic cpu_ack, cpu_stall, ldr_ack, CEN, WEN, OEN;
  logic [1:0] state_dbg;
  logic [CW-1:0] wait_cnt_dbg;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(Data2Mem),
    .ReadDataMem(ReadDataMem), .state_dbg(state_dbg), .wait_cnt_dbg(wait_cnt_dbg)
  );

  // SRAM: data appears only in the RD_LAT-th cycle after the access cycle.
  logic [DW-1:0] sram [0:(1<<AW)-1] = '{default: '0};
  logic [DW-1:0] rd_word;
  logic cen_q;
  int rd_cnt;
  assign ReadDataMem = (rd_cnt == 1) ? rd_word : 32'hBAD0_0BAD;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= 0;
      cen_q  <= 1'b1;
    end else begin
      cen_q <= CEN;
      if (!CEN && !WEN) sram[A] <= Data2Mem;
      if (!CEN && cen_q && !OEN) begin
        rd_cnt  <= RD_LAT;
        rd_word <= sram[A];
      end else if (rd_cnt > 0) begin
        rd_cnt <= rd_cnt - 1;
      end
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: '0};
  logic [DW-1:0] exp_c_q[$];
  logic [DW-1:0] exp_l_q[$];
  logic [DW-1:0] exp_c_rdata, exp_l_rdata, cur_wd;
  logic [AW-1:0] cur_addr;
  int t, rem, wmodel, c_ack_at, l_ack_at, cur_g, cur_ack;
  int c_mode, l_mode, c_ack_cnt, last_c_ack, last_l_ack, t0;
  bit c_is_rd, l_is_rd, cur_we;
  int vectors, miscompares;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s cyc=%0d observed=timeout expected=completion", tag, t);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 8);
    return (r < 8) ? AW'(r) : 7'h7E;
  endfunction

  task automatic set_cpu(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_ldr(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ldr_req = req; ldr_we = we; ldr_addr = a; ldr_wdata = d;
  endtask

  task automatic model_reset();
    rem = 0; wmodel = 0; c_ack_at = -1; l_ack_at = -1; cur_g = -1; cur_ack = -1;
    exp_c_q.delete(); exp_l_q.delete();
    exp_c_rdata = '0; exp_l_rdata = '0;
  endtask

  // One IDLE decision per access; an access occupies 3 cycles (+RD_LAT for reads).
  task automatic model_eval();
    bit to_l, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int len;
    check("cpu_stall", cpu_stall, cpu_req && (t != c_ack_at));
    if (rem == 0 && (cpu_req || ldr_req)) begin
      to_l = ldr_req && (!cpu_req || wmodel == MAX_WAIT);
      we = to_l ? ldr_we : cpu_we;
      a  = to_l ? ldr_addr : cpu_addr;
      d  = to_l ? ldr_wdata : cpu_wdata;
      len = we ? 3 : 3 + RD_LAT;
      if (we) ref_mem[a] = d;
      else if (to_l) exp_l_q.push_back(ref_mem[a]);
      else exp_c_q.push_back(ref_mem[a]);
      if (to_l) begin l_ack_at = t + len - 1; l_is_rd = !we; end
      else begin c_ack_at = t + len - 1; c_is_rd = !we; end
      cur_g = t; cur_ack = t + len - 1; cur_we = we; cur_addr = a; cur_wd = d;
      rem = len - 1;
      wmodel = (to_l || !ldr_req) ? 0 : ((wmodel < MAX_WAIT) ? wmodel + 1 : MAX_WAIT);
    end else begin
      if (rem > 0) rem--;
      if (!ldr_req) wmodel = 0;
    end
  endtask

  task automatic check_outputs();
    bit c_exp, l_exp, in_acc;
    c_exp = (t == c_ack_at);
    l_exp = (t == l_ack_at);
    if (c_exp && c_is_rd && exp_c_q.size() > 0) exp_c_rdata = exp_c_q.pop_front();
    if (l_exp && l_is_rd && exp_l_q.size() > 0) exp_l_rdata = exp_l_q.pop_front();
    in_acc = (t > cur_g) && (t < cur_ack);
    check("cpu_ack", cpu_ack, c_exp);
    check("ldr_ack", ldr_ack, l_exp);
    check("cpu_rdata", cpu_rdata, exp_c_rdata);
    check("ldr_rdata", ldr_rdata, exp_l_rdata);
    check("CEN", CEN, !in_acc);
    check("WEN", WEN, !(in_acc && cur_we && t == cur_g + 1));
    check("OEN", OEN, !(in_acc && !cur_we));
    check("wait_cnt", wait_cnt_dbg, wmodel);
    if (in_acc) check("A", A, cur_addr);
    if (in_acc && cur_we) check("Data2Mem", Data2Mem, cur_wd);
    if (cpu_ack) begin c_ack_cnt++; last_c_ack = t; end
    if (ldr_ack) last_l_ack = t;
  endtask

  task automatic post_ack();
    if (t == c_ack_at) begin
      if (c_mode == 2) set_cpu(1, 1, rand_addr(), $urandom());
      else if (c_mode == 1 && $urandom_range(0, 1) == 1)
        set_cpu(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
      else cpu_req = 1'b0;
    end
    if (t == l_ack_at) begin
      if (l_mode == 1 && $urandom_range(0, 1) == 1)
        set_ldr(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
      else ldr_req = 1'b0;
    end
  endtask

  task automatic cycle();
    if (c_mode == 1 && !cpu_req && $urandom_range(0, 2) == 0)
      set_cpu(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
    if (l_mode == 1 && !ldr_req && $urandom_range(0, 2) == 0)
      set_ldr(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
    #1;
    model_eval();
    @(posedge clk); #1;
    t++;
    check_outputs();
    post_ack();
  endtask

  task automatic wait_quiet(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (rem == 0 && !cpu_req && !ldr_req) return;
      cycle();
    end
    timeout("wait_quiet");
  endtask

  initial begin
    bit l_done;
    vectors = 0; miscompares = 0; t = 0; c_mode = 0; l_mode = 0;
    c_ack_cnt = 0; last_c_ack = -1; last_l_ack = -1;
    model_reset();
    set_cpu(0, 0, '0, '0);
    set_ldr(0, 0, '0, '0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_CEN", CEN, 1); check("rst_WEN", WEN, 1); check("rst_OEN", OEN, 1);
    check("rst_A", A, 0); check("rst_Data2Mem", Data2Mem, 0);
    check("rst_acks", {cpu_ack, ldr_ack}, 0);
    check("rst_rdata", {cpu_rdata, ldr_rdata}, 0);
    check("rst_state", state_dbg, 0); check("rst_wait", wait_cnt_dbg, 0);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // C write 0x05 <- DEADBEEF
    set_cpu(1, 1, 7'h05, 32'hDEADBEEF);
    cycle();
    check("t1_CEN", CEN, 0); check("t1_WEN", WEN, 0);
    check("t1_A", A, 7'h05); check("t1_Data2Mem", Data2Mem, 32'hDEADBEEF);
    cycle();
    check("t1_ack", cpu_ack, 1);
    wait_quiet(20);

    // C read 0x05
    set_cpu(1, 0, 7'h05, '0);
    cycle();
    check("t2_OEN_c1", OEN, 0);
    cycle();
    check("t2_OEN_c2", OEN, 0); check("t2_stall_c2", cpu_stall, 1);
    cycle();
    check("t2_ack", cpu_ack, 1); check("t2_rdata", cpu_rdata, 32'hDEADBEEF);
    wait_quiet(20);

    // Simultaneous requests: C first, L in the IDLE after C's DONE
    t0 = t;
    set_cpu(1, 1, 7'h0A, $urandom());
    set_ldr(1, 1, 7'h0B, $urandom());
    wait_quiet(40);
    check("t3_c_ack_cyc", last_c_ack, t0 + 2);
    check("t3_l_ack_cyc", last_l_ack, t0 + 5);

    // Starvation guard: continuous C, held L
    c_mode = 2; c_ack_cnt = 0; l_done = 0;
    set_cpu(1, 1, rand_addr(), $urandom());
    set_ldr(1, 1, 7'h20, $urandom());
    for (int i = 0; i < 100 && !l_done; i++) begin
      cycle();
      if (t == l_ack_at) l_done = 1;
    end
    if (!l_done) timeout("t4_l_grant");
    check("t4_c_acks_before_l", c_ack_cnt, 8);
    check("t4_wait_after_grant", wait_cnt_dbg, 0);
    c_mode = 0;
    wait_quiet(40);

    // Boundary address
    set_ldr(1, 1, 7'h7F, 32'h1);
    wait_quiet(20);
    set_cpu(1, 0, 7'h7F, '0);
    wait_quiet(20);
    check("t6_rdata_7F", cpu_rdata, 32'h1);

    // Randomized traffic on both ports
    c_mode = 1; l_mode = 1;
    repeat (400) cycle();
    c_mode = 0; l_mode = 0;
    wait_quiet(60);

    // Reset during the wait cycle of an L read
    set_ldr(1, 0, 7'h05, '0);
    cycle();
    cycle();
    check("t5_state_rdw", state_dbg, 2);
    #3 rst = 1'b1;
    #1;
    check("t5_CEN_async", CEN, 1); check("t5_OEN_async", OEN, 1);
    check("t5_state", state_dbg, 0); check("t5_ldr_rdata", ldr_rdata, 0);
    model_reset();
    set_ldr(0, 0, '0, '0);
    @(posedge clk); #1;
    t++;
    check("t5_no_ack", ldr_ack, 0); check("t5_CEN_hold", CEN, 1);
    check("t5_ldr_rdata_hold", ldr_rdata, 0);
    #3 rst = 1'b0;
    set_cpu(1, 0, 7'h7F, '0);
    wait_quiet(20);
    check("t5_recover_rdata", cpu_rdata, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
